// File: rtl/input_stream_feeder.sv
// input_stream_feeder: buffers the subject byte stream and hands CSR_traversal one character per request
module input_stream_feeder #(
  parameter int CHAR_W = 8,
  parameter int DEPTH = 16,
  parameter int POS_W = 20,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] s_char,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              char_req,
  input  logic              restart,
  output logic [CHAR_W-1:0] input_char,
  output logic              char_valid,
  output logic              char_last,
  output logic [POS_W-1:0]  char_pos,
  output logic              stream_done,
  output logic              req_err,
  output logic [CW-1:0]     fifo_count
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [CHAR_W:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic [CHAR_W-1:0] head_char;
  logic head_last, have, push, pop, err_nx, first;
  assign {head_last, head_char} = mem[rd_ptr];
  assign have = count != '0;
  assign push = s_valid & s_ready;
  assign count_nx = count + CW'(push) - CW'(pop);
  assign fifo_count = count;
  // Storage array carries no reset; only the pointers define what is valid
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {s_last, s_char};
  // Pointers, occupancy and a ready flag registered from the next occupancy
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      s_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
      s_ready <= count_nx != CW'(DEPTH);
    end
  // Request handling: pop decision, next state and rejected-request flag
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    err_nx = 1'b0;
    case (state)
      IDLE: if (char_req) begin
        pop = have;
        state_nx = !have ? WAIT : head_last ? DONE : IDLE;
      end
      WAIT: begin
        err_nx = char_req;
        pop = have;
        state_nx = !have ? WAIT : head_last ? DONE : IDLE;
      end
      DONE: begin
        err_nx = char_req;
        state_nx = restart ? IDLE : DONE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // Delivery registers; 'first' marks that the next delivery restarts numbering at 0
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      input_char <= '0;
      char_last <= 1'b0;
      char_valid <= 1'b0;
      char_pos <= '0;
      stream_done <= 1'b0;
      req_err <= 1'b0;
      first <= 1'b1;
    end else begin
      char_valid <= pop;
      req_err <= err_nx;
      stream_done <= (pop & head_last) ? 1'b1 : restart ? 1'b0 : stream_done;
      if (pop) begin
        input_char <= head_char;
        char_last <= head_last;
        char_pos <= (first | restart) ? '0 : char_pos + POS_W'(1);
        first <= 1'b0;
      end else if (restart) begin
        char_pos <= '0;
        first <= 1'b1;
      end
    end
endmodule

// File: doc/input_stream_feeder.md
Name: input_stream_feeder

Overview:
- Upstream stage of CSR_traversal in the regex engine.
- Buffers the subject-string byte stream in a small FIFO.
- Hands CSR_traversal one character per request pulse on its input_char_flag line, and tracks character position and end-of-string.
- Decouples the host/DMA byte source from the traversal's irregular per-character consumption rate.

Parameters:
- CHAR_W, 8, character width in bits
- DEPTH, 16, FIFO depth in characters (power of two, >= 2)
- POS_W, 20, width of the character position counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- s_char  input  CHAR_W  incoming character
- s_valid  input  1  s_char valid
- s_last  input  1  s_char is final character of the string
- s_ready  output  1  FIFO can accept; high when count < DEPTH
- char_req  input  1  single-cycle request for next character (driven by CSR_traversal input_char_flag)
- restart  input  1  single-cycle pulse: clear position/done for a new string
- input_char  output  CHAR_W  current character to CSR_traversal, held between deliveries
- char_valid  output  1  one-cycle pulse when input_char is updated
- char_last  output  1  delivered character was the string's last; held with input_char
- char_pos  output  POS_W  index of delivered character (first = 0)
- stream_done  output  1  sticky: last character delivered
- req_err  output  1  one-cycle pulse: request rejected
- fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset=0, async): FIFO emptied, state IDLE, all outputs 0.
  - s_ready rises on the first clock after release.
  - A reset mid-string discards buffered data and any pending request.
- FIFO:
  - Push on s_valid & s_ready; entry stores {s_last, s_char}.
  - Push and pop in the same cycle leave count unchanged.
  - s_ready derives from registered count; no push when full, even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, char_req=1, count>0: pop; next cycle input_char/char_last loaded, char_valid=1, char_pos updated. Latency 1 cycle. If the popped entry has last=1, go to DONE, else stay in IDLE.
  - IDLE, char_req=1, count=0: go to WAIT, request held pending.
  - WAIT, count>0: pop and deliver as above; go to DONE if last, else IDLE. A push at edge k gives char_valid in the cycle after edge k+1; there is no FIFO bypass.
  - WAIT, char_req=1: req_err pulse; the extra request is dropped and one request stays pending.
  - DONE, char_req=1: req_err pulse, no pop.
  - DONE, restart=1: go to IDLE; char_pos and stream_done cleared next cycle; FIFO contents kept.
  - restart in IDLE or WAIT: char_pos reset to 0 for the next delivery; a pending WAIT request is kept.
- Back-to-back requests: char_req on consecutive cycles in IDLE with data available gives one delivery per cycle (full throughput).
- char_pos:
  - First delivery after reset/restart = 0; each later delivery adds 1.
  - Wraps modulo 2^POS_W with no flag.
- stream_done: set in the same cycle as the char_valid carrying char_last=1; cleared only by restart or reset.
- char_req and restart in the same cycle in DONE: restart wins, request flagged req_err.
- input_char and char_last hold their last delivered value until the next delivery.

Test Plan:
- Reset, push "abc" with s_last on 'c', then issue 3 single-cycle char_req -> each char_valid 1 cycle after its req. char_pos 0,1,2. char_last=1 only on 'c'. stream_done=1 after third delivery.
- Request with empty FIFO, push 'x' at edge k -> char_valid in the cycle after edge k+1 with input_char=8'h78. A second char_req while waiting -> req_err pulse and a single delivery only.
- Push DEPTH=16 bytes with s_valid held high -> s_ready=0 with fifo_count=16. 17th byte not accepted until a pop. Pops return bytes in push order.
- After stream_done, char_req -> req_err=1, no char_valid, fifo_count unchanged. Then restart and char_req -> next buffered char delivered with char_pos=0.
- char_req held 4 cycles with 4 bytes buffered -> 4 consecutive char_valid pulses, char_pos 0..3.
- Assert reset mid-string with 5 bytes buffered and a request pending -> all outputs 0 immediately, fifo_count=0. No delivery after release until new data and a new request.
